// File: rtl/led_chaser_pkg.sv
// Shared types and the reload-pattern helper for the LED chaser.
package led_chaser_pkg;

  localparam int MAX_LEDS = 32;

  typedef enum logic [1:0] {
    MODE_OFF    = 2'd0,
    MODE_BLINK  = 2'd1,
    MODE_SHIFT  = 2'd2,
    MODE_BOUNCE = 2'd3
  } led_mode_t;

  typedef enum logic {
    DIR_LEFT,
    DIR_RIGHT
  } dir_t;

  // Pattern loaded whenever the selected mode changes (1 = lit).
  function automatic logic [MAX_LEDS-1:0] initial_pattern(input led_mode_t mode);
    case (mode)
      MODE_BLINK:  return '1;
      MODE_SHIFT:  return MAX_LEDS'(1);
      MODE_BOUNCE: return MAX_LEDS'(1);
      default:     return '0;
    endcase
  endfunction

endpackage

// File: rtl/sync_rise_detect.sv
// Two-flop synchroniser followed by a rising-edge detector.
// The strobe is decoded purely from registers, so it is glitch-free.
module sync_rise_detect (
  input  logic clk_in,
  input  logic rst,
  input  logic async_in,
  output logic rise_pulse
);

  logic s0_reg;
  logic s1_reg;
  logic prev_reg;

  // Synchronise the asynchronous input and keep one delayed copy for edge detection.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      s0_reg   <= 1'b0;
      s1_reg   <= 1'b0;
      prev_reg <= 1'b0;
    end else begin
      s0_reg   <= async_in;
      s1_reg   <= s0_reg;
      prev_reg <= s1_reg;
    end
  end

  assign rise_pulse = s1_reg & ~prev_reg;

endmodule

// File: rtl/led_chaser.sv
// LED pattern generator: every rising edge of the divided clock (treated as
// data) advances the pattern of the selected display mode unless paused.
module led_chaser
  import led_chaser_pkg::*;
#(
  parameter int NUM_LEDS   = 4,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                clk_in,
  input  logic                rst,
  input  logic                div_clk_in,
  input  led_mode_t           mode,
  input  logic                pause,
  output logic [NUM_LEDS-1:0] led,
  output logic                step_pulse
);

  logic [NUM_LEDS-1:0] pat_reg;
  logic [NUM_LEDS-1:0] pat_next;
  dir_t                dir_reg;
  dir_t                dir_next;
  led_mode_t           mode_q_reg;

  sync_rise_detect u_step_detect (
    .clk_in     (clk_in),
    .rst        (rst),
    .async_in   (div_clk_in),
    .rise_pulse (step_pulse)
  );

  // Next pattern: a mode change reloads, otherwise an unpaused step advances.
  always_comb begin
    pat_next = pat_reg;
    dir_next = dir_reg;
    if (mode != mode_q_reg) begin
      pat_next = NUM_LEDS'(initial_pattern(mode));
      if (mode == MODE_BOUNCE) begin
        dir_next = DIR_LEFT;
      end
    end else if (step_pulse && !pause) begin
      case (mode_q_reg)
        MODE_BLINK: pat_next = ~pat_reg;
        // Rotate left; the shift-right term brings the MSB back to the LSB
        // and degenerates to a hold for a single LED.
        MODE_SHIFT: pat_next = (pat_reg << 1) | (pat_reg >> (NUM_LEDS - 1));
        MODE_BOUNCE: begin
          // A single LED has nowhere to bounce to, so it simply stays lit.
          if (NUM_LEDS != 1) begin
            if (dir_reg == DIR_LEFT) begin
              if (pat_reg[NUM_LEDS-1]) begin
                dir_next = DIR_RIGHT;
                pat_next = pat_reg >> 1;
              end else begin
                pat_next = pat_reg << 1;
              end
            end else begin
              if (pat_reg[0]) begin
                dir_next = DIR_LEFT;
                pat_next = pat_reg << 1;
              end else begin
                pat_next = pat_reg >> 1;
              end
            end
          end
        end
        default: pat_next = '0;
      endcase
    end
  end

  // Pattern, bounce direction and last-seen mode registers.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      pat_reg    <= '0;
      dir_reg    <= DIR_LEFT;
      mode_q_reg <= MODE_OFF;
    end else begin
      pat_reg    <= pat_next;
      dir_reg    <= dir_next;
      mode_q_reg <= mode;
    end
  end

  // Pin polarity applied per LED straight from the pattern register.
  for (genvar gi = 0; gi < NUM_LEDS; gi++) begin : g_led
    assign led[gi] = ACTIVE_LOW ? ~pat_reg[gi] : pat_reg[gi];
  end

endmodule

// File: tb/tb_led_chaser.sv
// Self-checking bench for led_chaser: a 4-LED active-low instance and a
// 1-LED active-high instance share all stimulus.
module tb_led_chaser;
  import led_chaser_pkg::*;

  logic      clk = 1'b0;
  logic      rst = 1'b0;
  logic      div = 1'b0;
  led_mode_t mode = MODE_OFF;
  logic      pause = 1'b0;
  logic [3:0] led4;
  logic [0:0] led1;
  logic      step4;
  logic      step1;

  int assertions = 0;
  int failures   = 0;
  int step_seen  = 0;

  // Reference model state: mode last seen, steps since last reload, input history.
  led_mode_t mq;
  int        phase;
  bit        hist[$];
  bit        exp_step;

  typedef struct {
    bit        d;
    led_mode_t m;
    bit        p;
    logic [3:0] led;
    bit        stp;
  } vec_t;
  vec_t tbl[21];

  led_chaser u_dut4 (
    .clk_in(clk), .rst(rst), .div_clk_in(div), .mode(mode), .pause(pause),
    .led(led4), .step_pulse(step4)
  );

  led_chaser #(.NUM_LEDS(1), .ACTIVE_LOW(1'b0)) u_dut1 (
    .clk_in(clk), .rst(rst), .div_clk_in(div), .mode(mode), .pause(pause),
    .led(led1), .step_pulse(step1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertions++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Logical pattern from the mode rules: phase counts steps since the reload.
  function automatic logic [31:0] model_pat(input led_mode_t m, input int ph, input int n);
    logic [31:0] mask;
    int per, q, pos;
    mask = (n >= 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
    case (m)
      MODE_BLINK: return (ph % 2 == 0) ? mask : 32'd0;
      MODE_SHIFT: return 32'd1 << (ph % n);
      MODE_BOUNCE: begin
        if (n == 1) return 32'd1;
        per = 2 * n - 2;
        q   = ph % per;
        pos = (q < n) ? q : per - q;
        return 32'd1 << pos;
      end
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] model_led(input int n, input bit al);
    logic [31:0] mask, p;
    mask = (32'd1 << n) - 32'd1;
    p = model_pat(mq, phase, n);
    return al ? (~p & mask) : p;
  endfunction

  task automatic model_reset();
    hist = '{0, 0, 0, 0};
    mq = MODE_OFF;
    phase = 0;
    exp_step = 0;
  endtask

  // One clock edge as seen by the model: d/m/p are the values sampled at the edge.
  task automatic model_edge(input bit d, input led_mode_t m, input bit p);
    bit upd;
    hist.push_front(d);
    while (hist.size() > 4) void'(hist.pop_back());
    upd = hist[2] && !hist[3];
    if (m != mq) begin
      mq = m;
      phase = 0;
    end else if (upd && !p) begin
      phase++;
    end
    exp_step = hist[1] && !hist[2];
  endtask

  // Drive one cycle's inputs, clock it, then compare both DUTs to the model.
  task automatic cycle(input bit d, input led_mode_t m, input bit p);
    div = d; mode = m; pause = p;
    @(posedge clk);
    model_edge(d, m, p);
    @(negedge clk);
    if (step4) step_seen++;
    chk("led4", {28'd0, led4}, model_led(4, 1'b1));
    chk("step4", {31'd0, step4}, {31'd0, exp_step});
    chk("led1", {31'd0, led1}, model_led(1, 1'b0));
    chk("step1", {31'd0, step1}, {31'd0, exp_step});
  endtask

  // One isolated div_clk_in pulse; the resulting step has landed on return.
  task automatic pulse_edge(input led_mode_t m, input bit p);
    cycle(1, m, p); cycle(1, m, p); cycle(0, m, p); cycle(0, m, p);
  endtask

  // Asserted mid-cycle: outputs must reach reset values before the next edge.
  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    chk("rst_led4", {28'd0, led4}, 32'hF);
    chk("rst_step4", {31'd0, step4}, 32'd0);
    chk("rst_led1", {31'd0, led1}, 32'd0);
    chk("rst_step1", {31'd0, step1}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic chk_pat4(input string name, input logic [3:0] pat);
    chk(name, {28'd0, led4}, {28'd0, ~pat});
  endtask

  initial begin
    logic [3:0] shift_exp [5];
    logic [3:0] bounce_exp [7];
    int hold;
    bit d;
    led_mode_t m;
    bit p;

    shift_exp  = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    bounce_exp = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};

    // d, mode, pause, expected led (active low), expected step_pulse
    tbl[0]  = '{0, MODE_SHIFT, 0, 4'b1110, 0};
    tbl[1]  = '{1, MODE_SHIFT, 0, 4'b1110, 0};
    tbl[2]  = '{1, MODE_SHIFT, 0, 4'b1110, 1};
    tbl[3]  = '{0, MODE_SHIFT, 0, 4'b1101, 0};
    tbl[4]  = '{0, MODE_SHIFT, 0, 4'b1101, 0};
    tbl[5]  = '{1, MODE_SHIFT, 0, 4'b1101, 0};
    tbl[6]  = '{0, MODE_SHIFT, 0, 4'b1101, 1};
    tbl[7]  = '{0, MODE_BLINK, 0, 4'b0000, 0};
    tbl[8]  = '{1, MODE_BLINK, 0, 4'b0000, 0};
    tbl[9]  = '{0, MODE_BLINK, 0, 4'b0000, 1};
    tbl[10] = '{0, MODE_SHIFT, 0, 4'b1110, 0};
    tbl[11] = '{1, MODE_SHIFT, 0, 4'b1110, 0};
    tbl[12] = '{0, MODE_SHIFT, 0, 4'b1110, 1};
    tbl[13] = '{0, MODE_SHIFT, 0, 4'b1101, 0};
    tbl[14] = '{1, MODE_SHIFT, 1, 4'b1101, 0};
    tbl[15] = '{0, MODE_SHIFT, 1, 4'b1101, 1};
    tbl[16] = '{0, MODE_SHIFT, 1, 4'b1101, 0};
    tbl[17] = '{0, MODE_SHIFT, 0, 4'b1101, 0};
    tbl[18] = '{1, MODE_SHIFT, 0, 4'b1101, 0};
    tbl[19] = '{0, MODE_SHIFT, 0, 4'b1101, 1};
    tbl[20] = '{0, MODE_SHIFT, 0, 4'b1011, 0};

    model_reset();
    @(negedge clk);
    do_reset();

    // Hand-computed vectors: latency, mode-switch reload, pause discard.
    for (int i = 0; i < 21; i++) begin
      cycle(tbl[i].d, tbl[i].m, tbl[i].p);
      chk($sformatf("tbl%0d_led", i), {28'd0, led4}, {28'd0, tbl[i].led});
      chk($sformatf("tbl%0d_step", i), {31'd0, step4}, {31'd0, tbl[i].stp});
    end

    // Pattern is 0100 here; reset mid-cycle must blank the LEDs at once.
    chk_pat4("pre_rst_pat", 4'b0100);
    do_reset();

    // SHIFT: five steps after the reload.
    cycle(0, MODE_SHIFT, 0);
    chk_pat4("shift_reload", 4'b0001);
    for (int i = 0; i < 5; i++) begin
      pulse_edge(MODE_SHIFT, 0);
      chk_pat4($sformatf("shift_step%0d", i), shift_exp[i]);
    end

    // BOUNCE: seven steps across both ends.
    cycle(0, MODE_BOUNCE, 0);
    chk_pat4("bounce_reload", 4'b0001);
    for (int i = 0; i < 7; i++) begin
      pulse_edge(MODE_BOUNCE, 0);
      chk_pat4($sformatf("bounce_step%0d", i), bounce_exp[i]);
    end

    // BLINK with pause: strobes still seen, pattern held, next edge toggles.
    cycle(0, MODE_BLINK, 0);
    chk_pat4("blink_reload", 4'b1111);
    step_seen = 0;
    pulse_edge(MODE_BLINK, 1);
    pulse_edge(MODE_BLINK, 1);
    chk("pause_strobes", step_seen, 2);
    chk_pat4("pause_hold", 4'b1111);
    pulse_edge(MODE_BLINK, 0);
    chk_pat4("unpause_toggle", 4'b0000);

    // BLINK -> SHIFT on the very edge where step_pulse is high.
    cycle(1, MODE_BLINK, 0);
    cycle(1, MODE_BLINK, 0);
    chk("switch_step_hi", {31'd0, step4}, 32'd1);
    cycle(0, MODE_SHIFT, 0);
    chk_pat4("switch_reload", 4'b0001);
    cycle(0, MODE_SHIFT, 0);
    pulse_edge(MODE_SHIFT, 0);
    chk_pat4("switch_next", 4'b0010);

    // Divider-style input (3 low, 3 high), SHIFT held through reset release.
    mode = MODE_SHIFT;
    do_reset();
    cycle(0, MODE_SHIFT, 0);
    chk_pat4("div_first_edge", 4'b0001);
    for (int c = 0; c < 36; c++) begin
      cycle(bit'((c / 3) % 2), MODE_SHIFT, 0);
    end
    chk_pat4("div_six_steps", 4'b0100);

    // Randomised run against the model.
    d = 0; m = MODE_SHIFT; p = 0; hold = 0;
    for (int c = 0; c < 1500; c++) begin
      if (hold == 0) begin
        d = ~d;
        hold = $urandom_range(1, 4);
      end
      hold--;
      if ($urandom_range(0, 39) == 0) m = led_mode_t'($urandom_range(0, 3));
      if ($urandom_range(0, 29) == 0) p = ~p;
      if ($urandom_range(0, 299) == 0) do_reset();
      cycle(d, m, p);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
